// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: PC and instruction-memory word in, next-PC and IF/ID bundle out.
// master = surrounding pipeline (PC register, hazard unit, IMem); slave = the stage.
interface fetch_decode_stage_if #(
  parameter int WORD_W = 16,
  parameter int PC_W   = 32
);
  logic [PC_W-1:0]     PcIn;
  logic [WORD_W-1:0]   IMemWord;
  logic                Stall;
  logic                Flush;
  logic [PC_W-1:0]     PcNext;
  logic [2*WORD_W-1:0] InstrOut;
  logic [PC_W-1:0]     InstrPc;
  logic                Valid;
  logic                ImmPending;

  modport master (
    output PcIn, IMemWord, Stall, Flush,
    input  PcNext, InstrOut, InstrPc, Valid, ImmPending
  );

  modport slave (
    input  PcIn, IMemWord, Stall, Flush,
    output PcNext, InstrOut, InstrPc, Valid, ImmPending
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// IF/ID stage: fetches one 16-bit word per cycle and assembles one- or two-word
// instructions into a registered 32-bit bundle. Holds on Stall, squashes on Flush.
module fetch_decode_stage #(
  parameter int                WORD_W       = 16,
  parameter int                PC_W         = 32,
  parameter int                IMM_FLAG_BIT = 15,
  parameter logic [WORD_W-1:0] NOP_WORD     = '0
) (
  input logic                 Clk,
  input logic                 Rst,
  fetch_decode_stage_if.slave bus
);
  typedef enum logic {FETCH_OP = 1'b0, FETCH_IMM = 1'b1} state_t;

  state_t              state;
  logic [WORD_W-1:0]   op_word;
  logic [PC_W-1:0]     op_pc;
  logic [2*WORD_W-1:0] instr;
  logic [PC_W-1:0]     instr_pc;
  logic                valid;
  logic                imm_pending;

  // Sequential next-PC only; redirects are resolved in the PC register itself.
  assign bus.PcNext = bus.Stall ? bus.PcIn : bus.PcIn + PC_W'(1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= FETCH_OP;
      op_word     <= '0;
      op_pc       <= '0;
      instr       <= {NOP_WORD, {WORD_W{1'b0}}};
      instr_pc    <= '0;
      valid       <= 1'b0;
      imm_pending <= 1'b0;
    end else if (bus.Flush) begin
      // The word on IMemWord this cycle belongs to the squashed path; drop it.
      state       <= FETCH_OP;
      op_word     <= '0;
      instr       <= {NOP_WORD, {WORD_W{1'b0}}};
      valid       <= 1'b0;
      imm_pending <= 1'b0;
    end else if (!bus.Stall) begin
      case (state)
        FETCH_OP: begin
          if (bus.IMemWord[IMM_FLAG_BIT]) begin
            op_word     <= bus.IMemWord;
            op_pc       <= bus.PcIn;
            instr       <= {NOP_WORD, {WORD_W{1'b0}}};
            valid       <= 1'b0;
            imm_pending <= 1'b1;
            state       <= FETCH_IMM;
          end else begin
            instr    <= {bus.IMemWord, {WORD_W{1'b0}}};
            instr_pc <= bus.PcIn;
            valid    <= 1'b1;
          end
        end
        FETCH_IMM: begin
          // Immediate word is taken verbatim, its flag bit is not inspected.
          instr       <= {op_word, bus.IMemWord};
          instr_pc    <= op_pc;
          valid       <= 1'b1;
          imm_pending <= 1'b0;
          state       <= FETCH_OP;
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

  assign bus.InstrOut   = instr;
  assign bus.InstrPc    = instr_pc;
  assign bus.Valid      = valid;
  assign bus.ImmPending = imm_pending;
endmodule
